// File: rtl/mips_mem_pkg.sv
// Shared constants for the MIPS instruction memory and its loader.
// Holds the default depth, loader state encoding and word geometry.
package mips_mem_pkg;

    localparam int DEFAULT_INST_DEPTH = 1024;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [1:0] LOADER_IDLE = 2'd0;
    localparam logic [1:0] LOADER_LOAD = 2'd1;
    localparam logic [1:0] LOADER_DONE = 2'd2;

endpackage

// File: rtl/inst_loader.sv
// Byte-stream loader for the instruction memory write port.
// Packs big-endian words, holds the CPU in reset while loading.
module inst_loader
    import mips_mem_pkg::*;
#(
    parameter int INST_DEPTH = DEFAULT_INST_DEPTH,
    localparam int ADDR_W = $clog2(INST_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       checksum
);

    logic [1:0]      state;
    logic [ADDR_W:0] word_cnt;
    logic [ADDR_W:0] word_addr;
    logic [1:0]      byte_idx;
    logic [23:0]     shift;

    logic            accept;
    logic            last_byte;
    logic            last_word;
    logic            start_ok;
    logic [31:0]     word;

    assign s_ready  = (state == LOADER_LOAD);
    assign busy     = (state == LOADER_LOAD) || (state == LOADER_DONE);
    assign cpu_hold = busy;

    assign accept    = s_valid && s_ready;
    assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));
    assign last_word = ((word_addr + 1'b1) == word_cnt);
    assign start_ok  = (word_count != '0) &&
                       (word_count <= (ADDR_W + 1)'(INST_DEPTH));
    assign word      = {shift, s_data};

    // Loader FSM plus byte assembly and word write issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOADER_IDLE;
            word_cnt  <= '0;
            word_addr <= '0;
            byte_idx  <= '0;
            shift     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            checksum  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                LOADER_IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            word_cnt  <= word_count;
                            word_addr <= '0;
                            byte_idx  <= '0;
                            checksum  <= '0;
                            state     <= LOADER_LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOADER_LOAD: begin
                    if (abort) begin
                        // Partial word is dropped; no write on this edge.
                        err      <= 1'b1;
                        byte_idx <= '0;
                        state    <= LOADER_IDLE;
                    end else if (accept) begin
                        if (last_byte) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= word;
                            mem_addr  <= word_addr[ADDR_W-1:0];
                            checksum  <= checksum ^ word;
                            word_addr <= word_addr + 1'b1;
                            byte_idx  <= '0;
                            if (last_word) begin
                                done  <= 1'b1;
                                state <= LOADER_DONE;
                            end
                        end else begin
                            case (byte_idx)
                                2'd0:    shift[23:16] <= s_data;
                                2'd1:    shift[15:8]  <= s_data;
                                default: shift[7:0]   <= s_data;
                            endcase
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                LOADER_DONE: begin
                    state <= LOADER_IDLE;
                end
                default: begin
                    state <= LOADER_IDLE;
                end
            endcase
        end
    end

endmodule
